// File: rtl/cov_window_sequencer.sv
// cov_window_sequencer: runs coverage collection in fixed-length windows and streams one report per window.
// Optional feature macro: COV_SEQ_CUMULATIVE_EN (sticky per-point mask, reported on rpt_cum_covered_o).
module cov_window_sequencer #(
  parameter int NUM_POINTS = 13,
  parameter int CNT_W      = 32,
  parameter int WIN_W      = 16,
  localparam int PC_W      = $clog2(NUM_POINTS + 1)
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic [WIN_W-1:0]            win_len_i,
  input  logic [7:0]                  num_windows_i,
  input  logic [NUM_POINTS*CNT_W-1:0] hit_cnt_i,
  output logic                        cov_en_o,
  output logic                        cnt_clr_o,
  output logic                        busy_o,
  output logic                        rpt_valid_o,
  input  logic                        rpt_ready_i,
  output logic [PC_W-1:0]             rpt_covered_o,
  output logic [7:0]                  rpt_window_o,
  output logic                        rpt_partial_o,
  output logic [PC_W-1:0]             rpt_cum_covered_o
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SNAP, REPORT} state_t;

  state_t                state_q, state_d;
  logic [WIN_W-1:0]      win_len_q, win_len_d;
  logic [WIN_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            num_win_q, num_win_d;
  logic [7:0]            index_q, index_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  partial_q, partial_d;
  logic [PC_W-1:0]       covered_q, covered_d;
  logic                  rpt_partial_q, rpt_partial_d;
  logic [NUM_POINTS-1:0] hits;
  logic                  last_win;

  function automatic logic [PC_W-1:0] popcnt(input logic [NUM_POINTS-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NUM_POINTS; i++) popcnt = popcnt + {{(PC_W-1){1'b0}}, v[i]};
  endfunction

  // Reduce each hit counter to a covered flag: any nonzero count means the point was hit.
  always_comb begin
    hits = '0;
    for (int i = 0; i < NUM_POINTS; i++) hits[i] = |hit_cnt_i[i*CNT_W +: CNT_W];
  end

  assign last_win = (num_win_q != 8'd0) && (index_q + 8'd1 == num_win_q);

  // Next-state logic: window timing, stop bookkeeping and report capture.
  always_comb begin
    state_d       = state_q;
    win_len_d     = win_len_q;
    cnt_d         = cnt_q;
    num_win_d     = num_win_q;
    index_d       = index_q;
    stop_pend_d   = stop_pend_q | (stop_i && state_q != IDLE);
    partial_d     = partial_q;
    covered_d     = covered_q;
    rpt_partial_d = rpt_partial_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d     = CLEAR;
        win_len_d   = (win_len_i == '0) ? WIN_W'(1) : win_len_i;
        num_win_d   = num_windows_i;
        index_d     = 8'd0;
        stop_pend_d = 1'b0;
      end
      CLEAR: begin
        state_d   = RUN;
        cnt_d     = win_len_q - WIN_W'(1);
        partial_d = 1'b0;
      end
      RUN: begin
        state_d   = (stop_i || cnt_q == '0) ? SNAP : RUN;
        cnt_d     = (cnt_q == '0) ? cnt_q : cnt_q - WIN_W'(1);
        partial_d = stop_i && cnt_q != '0;
      end
      SNAP: begin
        state_d       = REPORT;
        covered_d     = popcnt(hits);
        rpt_partial_d = partial_q;
      end
      REPORT: if (rpt_ready_i) begin
        index_d = index_q + 8'd1;
        state_d = (stop_pend_q || stop_i || last_win) ? IDLE : CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and report registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      win_len_q     <= '0;
      cnt_q         <= '0;
      num_win_q     <= '0;
      index_q       <= '0;
      stop_pend_q   <= 1'b0;
      partial_q     <= 1'b0;
      covered_q     <= '0;
      rpt_partial_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_len_q     <= win_len_d;
      cnt_q         <= cnt_d;
      num_win_q     <= num_win_d;
      index_q       <= index_d;
      stop_pend_q   <= stop_pend_d;
      partial_q     <= partial_d;
      covered_q     <= covered_d;
      rpt_partial_q <= rpt_partial_d;
    end
  end

`ifdef COV_SEQ_CUMULATIVE_EN
  logic [NUM_POINTS-1:0] mask_q, mask_d;
  logic [PC_W-1:0]       cum_q, cum_d;

  // Sticky mask accumulates covered points across a run; cleared when a run starts.
  always_comb begin
    mask_d = mask_q;
    cum_d  = cum_q;
    if (state_q == IDLE && start_i) mask_d = '0;
    if (state_q == SNAP) begin
      mask_d = mask_q | hits;
      cum_d  = popcnt(mask_q | hits);
    end
  end

  // Cumulative mask and count registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mask_q <= '0;
      cum_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cum_q  <= cum_d;
    end
  end

  assign rpt_cum_covered_o = cum_q;
`else
  assign rpt_cum_covered_o = '0;
`endif

  assign cov_en_o      = state_q == RUN;
  assign cnt_clr_o     = state_q == CLEAR;
  assign busy_o        = state_q != IDLE;
  assign rpt_valid_o   = state_q == REPORT;
  assign rpt_covered_o = covered_q;
  assign rpt_window_o  = index_q;
  assign rpt_partial_o = rpt_partial_q;
endmodule
